uart_rx_ctrl: RTL

//  UART receive frame controller; consumes the majority-voted sampled_bit from the

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/uart_rx_ctrl_if.sv | 39 +++
 rtl/uart_rx_edge_bit_cnt.sv | 49 ++++
 rtl/uart_rx_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared encodings and defaults for the UART receive frame controller.
package uart_rx_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PRESC_W_DEF    = 6;
  localparam int EDGE_W_DEF     = 5;

  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the receive controller (slave) and its line/sampling/FIFO side (master).
// err_count exists only when UART_RX_ERR_CNT_EN is defined.
interface uart_rx_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6,
  parameter int EDGE_W     = 5
);
  logic                  rx_in;
  logic [PRESC_W-1:0]    prescale;
  logic                  par_en;
  logic                  par_typ;
  logic                  sampled_bit;
  logic [EDGE_W-1:0]     edge_count;
  logic                  data_sample_en;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  parity_error;
  logic                  stop_error;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0]            err_count;
`endif

  modport slave (
    input  rx_in, prescale, par_en, par_typ, sampled_bit,
    output edge_count, data_sample_en, p_data, data_valid, parity_error, stop_error
`ifdef UART_RX_ERR_CNT_EN
    , output err_count
`endif
  );

  modport master (
    output rx_in, prescale, par_en, par_typ, sampled_bit,
    input  edge_count, data_sample_en, p_data, data_valid, parity_error, stop_error
`ifdef UART_RX_ERR_CNT_EN
    , input err_count
`endif
  );

endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter and data-bit counter; bit_end fires on the last edge of each bit.
module uart_rx_edge_bit_cnt #(
  parameter int EDGE_W = 5,
  parameter int BCNT_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cnt_en,
  input  logic              bit_cnt_en,
  input  logic [EDGE_W-1:0] edge_last,
  output logic [EDGE_W-1:0] edge_count,
  output logic [BCNT_W-1:0] bit_cnt,
  output logic              bit_end
);

  logic [EDGE_W-1:0] edge_count_q, edge_count_d;
  logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;

  assign bit_end = cnt_en && (edge_count_q == edge_last);

  always_comb begin
    edge_count_d = edge_count_q;
    bit_cnt_d    = bit_cnt_q;
    if (!cnt_en || bit_end) begin
      edge_count_d = '0;
    end else begin
      edge_count_d = edge_count_q + EDGE_W'(1);
    end
    if (!bit_cnt_en) begin
      bit_cnt_d = '0;
    end else if (bit_end) begin
      bit_cnt_d = bit_cnt_q + BCNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_count_q <= '0;
      bit_cnt_q    <= '0;
    end else begin
      edge_count_q <= edge_count_d;
      bit_cnt_q    <= bit_cnt_d;
    end
  end

  assign edge_count = edge_count_q;
  assign bit_cnt    = bit_cnt_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detect, LSB-first deserializer, parity and stop checks.
// Optional UART_RX_ERR_CNT_EN adds a saturating bad-frame counter on err_count.
//
// state  | meaning
// IDLE   | line idle, counters held at 0, waiting for rx_in low
// START  | timing start bit; high vote at bit end is a glitch
// DATA   | shifting data bits into p_data, LSB first
// PARITY | comparing parity bit against latched type
// STOP   | checking stop bit, emitting data_valid / stop_error
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESC_W    = PRESC_W_DEF,
  parameter int EDGE_W     = EDGE_W_DEF
) (
  input logic           clk,
  input logic           rst,
  uart_rx_ctrl_if.slave bus
);

  localparam int BCNT_W = $clog2(DATA_WIDTH);

  rx_state_e             state_q, state_d;
  logic [EDGE_W-1:0]     presc_m1_q, presc_m1_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  bad_q, bad_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  parity_error_q, parity_error_d;
  logic                  stop_error_q, stop_error_d;

  logic [EDGE_W-1:0]     presc_m1_new;
  logic [EDGE_W-1:0]     edge_count;
  logic [BCNT_W-1:0]     bit_cnt;
  logic                  bit_end;
  logic                  cnt_en;
  logic                  bit_cnt_en;

  assign cnt_en     = (state_q != ST_IDLE);
  assign bit_cnt_en = (state_q == ST_DATA);

  uart_rx_edge_bit_cnt #(
    .EDGE_W (EDGE_W),
    .BCNT_W (BCNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .cnt_en     (cnt_en),
    .bit_cnt_en (bit_cnt_en),
    .edge_last  (presc_m1_q),
    .edge_count (edge_count),
    .bit_cnt    (bit_cnt),
    .bit_end    (bit_end)
  );

  // Unsupported ratios fall back to 8 so a bad setting still yields a usable bit time.
  always_comb begin
    presc_m1_new = EDGE_W'(PRESC_8 - 1);
    if (bus.prescale == PRESC_W'(PRESC_16)) begin
      presc_m1_new = EDGE_W'(PRESC_16 - 1);
    end else if (bus.prescale == PRESC_W'(PRESC_32)) begin
      presc_m1_new = EDGE_W'(PRESC_32 - 1);
    end
  end

  always_comb begin
    state_d        = state_q;
    presc_m1_d     = presc_m1_q;
    par_en_d       = par_en_q;
    par_typ_d      = par_typ_q;
    bad_d          = bad_q;
    p_data_d       = p_data_q;
    data_valid_d   = 1'b0;
    parity_error_d = 1'b0;
    stop_error_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!bus.rx_in) begin
          state_d    = ST_START;
          presc_m1_d = presc_m1_new;
          par_en_d   = bus.par_en;
          par_typ_d  = bus.par_typ;
          bad_d      = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = bus.sampled_bit ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          p_data_d[bit_cnt] = bus.sampled_bit;
          if (bit_cnt == BCNT_W'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          if (bus.sampled_bit != (^p_data_q ^ par_typ_q)) begin
            parity_error_d = 1'b1;
            bad_d          = 1'b1;
          end
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (!bus.sampled_bit) begin
            stop_error_d = 1'b1;
          end else if (!bad_q) begin
            data_valid_d = 1'b1;
          end
          // A low line here is the next start bit; re-arm without an idle cycle.
          if (!bus.rx_in) begin
            state_d    = ST_START;
            presc_m1_d = presc_m1_new;
            par_en_d   = bus.par_en;
            par_typ_d  = bus.par_typ;
            bad_d      = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      presc_m1_q     <= EDGE_W'(PRESC_8 - 1);
      par_en_q       <= 1'b0;
      par_typ_q      <= 1'b0;
      bad_q          <= 1'b0;
      p_data_q       <= '0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_m1_q     <= presc_m1_d;
      par_en_q       <= par_en_d;
      par_typ_q      <= par_typ_d;
      bad_q          <= bad_d;
      p_data_q       <= p_data_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      stop_error_q   <= stop_error_d;
    end
  end

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // A frame with both errors is counted once, at its stop bit.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_q == ST_STOP) && bit_end && (!bus.sampled_bit || bad_q) &&
        (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_count = err_cnt_q;
`endif

  assign bus.edge_count     = edge_count;
  assign bus.data_sample_en = cnt_en;
  assign bus.p_data         = p_data_q;
  assign bus.data_valid     = data_valid_q;
  assign bus.parity_error   = parity_error_q;
  assign bus.stop_error     = stop_error_q;

endmodule
